axi_burst_mem_writer: RTL and testbench

AXI_BURST_MEM_WRITER -- requirements
Module: axi_burst_mem_writer

---
 rtl/axi_burst_mem_writer.sv | 181 ++++++++++++++++++
 tb/tb_axi_burst_mem_writer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_mem_writer.sv
// Streams a byte-length write request out as aligned AXI INCR bursts, splitting at
// MAX_BURST and 4 KiB boundaries, and returns a single OK/ERROR status per request.
module axi_burst_mem_writer #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 32,
    parameter int ID_W            = 4,
    parameter int AXI_ID          = 0,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [ADDR_W-1:0]   req_length,
    input  logic                req_vld,
    output logic                req_rdy,
    input  logic [DATA_W-1:0]   data_in_data,
    input  logic                data_in_vld,
    output logic                data_in_rdy,
    output logic                resp_status,
    output logic                resp_vld,
    input  logic                resp_rdy,
    output logic [ID_W-1:0]     axi_aw_awid,
    output logic [ADDR_W-1:0]   axi_aw_awaddr,
    output logic [2:0]          axi_aw_awsize,
    output logic [7:0]          axi_aw_awlen,
    output logic [1:0]          axi_aw_awburst,
    output logic                axi_aw_awvalid,
    input  logic                axi_aw_awready,
    output logic [DATA_W-1:0]   axi_w_wdata,
    output logic [DATA_W/8-1:0] axi_w_wstrb,
    output logic                axi_w_wlast,
    output logic                axi_w_wvalid,
    input  logic                axi_w_wready,
    input  logic [2:0]          axi_b_bresp,
    input  logic [ID_W-1:0]     axi_b_bid,
    input  logic                axi_b_bvalid,
    output logic                axi_b_bready
);

    localparam int BYTES = DATA_W / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int OW    = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, DRAIN, RESP} state_t;

    state_t             state_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [ADDR_W-1:0]  beats_rem_reg;
    logic [ADDR_W-1:0]  bytes_rem_reg;
    logic [7:0]         awlen_reg;
    logic [7:0]         beat_cnt_reg;
    logic [OW-1:0]      outstanding_reg;
    logic               err_reg;

    logic [ADDR_W:0]    boundary_beats;
    logic [ADDR_W:0]    burst_beats;
    logic [ADDR_W:0]    total_beats;
    logic [7:0]         awlen_next;
    logic [ADDR_W-1:0]  addr_step;
    logic               misaligned;
    logic               in_data;
    logic               aw_hs;
    logic               w_hs;
    logic               b_hs;
    logic               wlast_int;
    logic               unused_bid;

    assign unused_bid = ^axi_b_bid;

    // Beats left before the next 4 KiB page; only meaningful when the address space spans pages.
    generate
        if (ADDR_W > 12) begin : g_page
            logic [12:0] to_page;
            assign to_page        = (13'd4096 - {1'b0, addr_reg[11:0]}) >> LSB;
            assign boundary_beats = {{(ADDR_W-12){1'b0}}, to_page};
        end else begin : g_no_page
            assign boundary_beats = '1;
        end
    endgenerate

    always_comb begin
        burst_beats = {1'b0, beats_rem_reg};
        if (burst_beats > (ADDR_W+1)'(MAX_BURST))
            burst_beats = (ADDR_W+1)'(MAX_BURST);
        if (burst_beats > boundary_beats)
            burst_beats = boundary_beats;
    end

    assign awlen_next  = 8'(burst_beats - 1'b1);
    assign addr_step   = ADDR_W'(burst_beats << LSB);
    assign total_beats = ({1'b0, req_length} + (ADDR_W+1)'(BYTES - 1)) >> LSB;
    assign misaligned  = (req_addr & ADDR_W'(BYTES - 1)) != '0;

    assign in_data   = (state_reg == DATA);
    assign aw_hs     = axi_aw_awvalid && axi_aw_awready;
    assign w_hs      = axi_w_wvalid && axi_w_wready;
    assign b_hs      = axi_b_bvalid && axi_b_bready;
    assign wlast_int = in_data && (beat_cnt_reg == awlen_reg);

    assign req_rdy        = (state_reg == IDLE) && !rst;
    assign axi_aw_awid    = ID_W'(AXI_ID);
    assign axi_aw_awaddr  = addr_reg;
    assign axi_aw_awsize  = 3'(LSB);
    assign axi_aw_awlen   = (state_reg == ADDR) ? awlen_next : 8'd0;
    assign axi_aw_awburst = 2'b01;
    assign axi_aw_awvalid = (state_reg == ADDR) && (outstanding_reg != OW'(MAX_OUTSTANDING));
    assign axi_w_wdata    = data_in_data;
    assign axi_w_wvalid   = in_data && data_in_vld;
    assign data_in_rdy    = in_data && axi_w_wready;
    assign axi_w_wlast    = wlast_int;
    // Shifting ones by the remaining byte count yields the tail mask, or all ones once >= BYTES.
    assign axi_w_wstrb    = !in_data ? '0 :
                            (beats_rem_reg == ADDR_W'(1)) ? ~({BYTES{1'b1}} << bytes_rem_reg) :
                            {BYTES{1'b1}};
    assign axi_b_bready   = (outstanding_reg != '0);
    assign resp_vld       = (state_reg == RESP);
    assign resp_status    = (state_reg == RESP) && err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            addr_reg        <= '0;
            beats_rem_reg   <= '0;
            bytes_rem_reg   <= '0;
            awlen_reg       <= '0;
            beat_cnt_reg    <= '0;
            outstanding_reg <= '0;
            err_reg         <= 1'b0;
        end else begin
            case ({aw_hs, b_hs})
                2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
                2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
                default: outstanding_reg <= outstanding_reg;
            endcase
            if (b_hs && axi_b_bresp != 3'd0)
                err_reg <= 1'b1;

            case (state_reg)
                IDLE: if (req_vld) begin
                    if (req_length == '0) begin
                        state_reg <= RESP;
                    end else if (misaligned) begin
                        err_reg   <= 1'b1;
                        state_reg <= RESP;
                    end else begin
                        addr_reg      <= req_addr;
                        beats_rem_reg <= ADDR_W'(total_beats);
                        bytes_rem_reg <= req_length;
                        state_reg     <= ADDR;
                    end
                end
                ADDR: if (aw_hs) begin
                    awlen_reg    <= awlen_next;
                    addr_reg     <= addr_reg + addr_step;
                    beat_cnt_reg <= '0;
                    state_reg    <= DATA;
                end
                DATA: if (w_hs) begin
                    beats_rem_reg <= beats_rem_reg - 1'b1;
                    bytes_rem_reg <= (bytes_rem_reg > ADDR_W'(BYTES)) ?
                                     bytes_rem_reg - ADDR_W'(BYTES) : '0;
                    if (wlast_int) begin
                        beat_cnt_reg <= '0;
                        state_reg    <= (beats_rem_reg != ADDR_W'(1)) ? ADDR : DRAIN;
                    end else begin
                        beat_cnt_reg <= beat_cnt_reg + 1'b1;
                    end
                end
                DRAIN: if (outstanding_reg == '0)
                    state_reg <= RESP;
                RESP: if (resp_rdy) begin
                    err_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_mem_writer.sv
// Directed bench for axi_burst_mem_writer: the bench plays the AXI slave by hand
// and checks each handshake against hand-computed burst splits and strobes.
module tb_axi_burst_mem_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req_addr, req_length;
    logic        req_vld, req_rdy;
    logic [31:0] data_in_data;
    logic        data_in_vld, data_in_rdy;
    logic        resp_status, resp_vld, resp_rdy;
    logic [3:0]  axi_aw_awid;
    logic [15:0] axi_aw_awaddr;
    logic [2:0]  axi_aw_awsize;
    logic [7:0]  axi_aw_awlen;
    logic [1:0]  axi_aw_awburst;
    logic        axi_aw_awvalid, axi_aw_awready;
    logic [31:0] axi_w_wdata;
    logic [3:0]  axi_w_wstrb;
    logic        axi_w_wlast, axi_w_wvalid, axi_w_wready;
    logic [2:0]  axi_b_bresp;
    logic [3:0]  axi_b_bid;
    logic        axi_b_bvalid, axi_b_bready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_burst_mem_writer dut (
        .clk(clk), .rst(rst),
        .req_addr(req_addr), .req_length(req_length), .req_vld(req_vld), .req_rdy(req_rdy),
        .data_in_data(data_in_data), .data_in_vld(data_in_vld), .data_in_rdy(data_in_rdy),
        .resp_status(resp_status), .resp_vld(resp_vld), .resp_rdy(resp_rdy),
        .axi_aw_awid(axi_aw_awid), .axi_aw_awaddr(axi_aw_awaddr), .axi_aw_awsize(axi_aw_awsize),
        .axi_aw_awlen(axi_aw_awlen), .axi_aw_awburst(axi_aw_awburst),
        .axi_aw_awvalid(axi_aw_awvalid), .axi_aw_awready(axi_aw_awready),
        .axi_w_wdata(axi_w_wdata), .axi_w_wstrb(axi_w_wstrb), .axi_w_wlast(axi_w_wlast),
        .axi_w_wvalid(axi_w_wvalid), .axi_w_wready(axi_w_wready),
        .axi_b_bresp(axi_b_bresp), .axi_b_bid(axi_b_bid),
        .axi_b_bvalid(axi_b_bvalid), .axi_b_bready(axi_b_bready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [15:0] a, input logic [15:0] l);
        req_addr = a; req_length = l; req_vld = 1'b1;
        #1;
        check("req_rdy", 32'(req_rdy), 32'd1);
        $display("REQ addr=%h len=%0d", a, l);
        @(negedge clk);
        req_vld = 1'b0;
    endtask

    task automatic wait_aw();
        int n = 0;
        #1;
        while (!axi_aw_awvalid && n < 40) begin
            @(negedge clk); #1; n++;
        end
        check("aw_wait", 32'(axi_aw_awvalid), 32'd1);
    endtask

    task automatic do_aw(input logic [15:0] exp_addr, input logic [7:0] exp_len);
        wait_aw();
        check("awaddr", 32'(axi_aw_awaddr), 32'(exp_addr));
        check("awlen", 32'(axi_aw_awlen), 32'(exp_len));
        check("awsize", 32'(axi_aw_awsize), 32'd2);
        check("awburst", 32'(axi_aw_awburst), 32'd1);
        check("awid", 32'(axi_aw_awid), 32'd0);
        // Hold off one cycle: payload must not move while awready is low.
        @(negedge clk); #1;
        check("aw_hold_valid", 32'(axi_aw_awvalid), 32'd1);
        check("aw_hold_addr", 32'(axi_aw_awaddr), 32'(exp_addr));
        check("aw_hold_len", 32'(axi_aw_awlen), 32'(exp_len));
        axi_aw_awready = 1'b1;
        $display("AW addr=%h awlen=%0d", axi_aw_awaddr, axi_aw_awlen);
        @(negedge clk);
        axi_aw_awready = 1'b0;
    endtask

    task automatic do_w(input int n, input logic [3:0] last_strb, input bit is_final);
        for (int i = 0; i < n; i++) begin
            data_in_data = 32'hD000_0000 + 32'(i);
            data_in_vld  = 1'b1;
            axi_w_wready = 1'b1;
            #1;
            check("wvalid", 32'(axi_w_wvalid), 32'd1);
            check("data_in_rdy", 32'(data_in_rdy), 32'd1);
            check("wdata", axi_w_wdata, 32'hD000_0000 + 32'(i));
            check("wstrb", 32'(axi_w_wstrb), (is_final && i == n-1) ? 32'(last_strb) : 32'hF);
            check("wlast", 32'(axi_w_wlast), (i == n-1) ? 32'd1 : 32'd0);
            $display("W beat=%0d strb=%h last=%0d", i, axi_w_wstrb, axi_w_wlast);
            @(negedge clk);
        end
        data_in_vld  = 1'b0;
        axi_w_wready = 1'b0;
    endtask

    task automatic do_b(input logic [2:0] bresp);
        axi_b_bvalid = 1'b1; axi_b_bresp = bresp; axi_b_bid = 4'h5;
        #1;
        check("bready", 32'(axi_b_bready), 32'd1);
        $display("B bresp=%0d", bresp);
        @(negedge clk);
        axi_b_bvalid = 1'b0; axi_b_bresp = 3'd0;
    endtask

    task automatic do_resp(input logic exp_status);
        int n = 0;
        #1;
        while (!resp_vld && n < 40) begin
            @(negedge clk); #1; n++;
        end
        check("resp_wait", 32'(resp_vld), 32'd1);
        check("resp_status", 32'(resp_status), 32'(exp_status));
        check("resp_no_aw", 32'(axi_aw_awvalid), 32'd0);
        resp_rdy = 1'b1;
        $display("RESP status=%0d", resp_status);
        @(negedge clk);
        resp_rdy = 1'b0;
        #1;
        check("idle_after_resp", 32'(req_rdy), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        req_addr = '0; req_length = '0; req_vld = 1'b0;
        data_in_data = '0; data_in_vld = 1'b0; resp_rdy = 1'b0;
        axi_aw_awready = 1'b0; axi_w_wready = 1'b0;
        axi_b_bresp = '0; axi_b_bid = '0; axi_b_bvalid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_rdy", 32'(req_rdy), 32'd0);
        check("rst_awvalid", 32'(axi_aw_awvalid), 32'd0);
        check("rst_wvalid", 32'(axi_w_wvalid), 32'd0);
        check("rst_resp_vld", 32'(resp_vld), 32'd0);
        check("rst_resp_status", 32'(resp_status), 32'd0);
        check("rst_awaddr", 32'(axi_aw_awaddr), 32'd0);
        check("rst_awlen", 32'(axi_aw_awlen), 32'd0);
        check("rst_wstrb", 32'(axi_w_wstrb), 32'd0);
        check("rst_wlast", 32'(axi_w_wlast), 32'd0);
        check("rst_bready", 32'(axi_b_bready), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Two-beat aligned write; data offered before AW completes must be refused.
        send_req(16'h0100, 16'd8);
        data_in_vld = 1'b1; axi_w_wready = 1'b1;
        #1;
        check("early_data_rdy", 32'(data_in_rdy), 32'd0);
        check("early_wvalid", 32'(axi_w_wvalid), 32'd0);
        data_in_vld = 1'b0; axi_w_wready = 1'b0;
        do_aw(16'h0100, 8'd1);
        do_w(2, 4'hF, 1'b1);
        do_b(3'd0);
        do_resp(1'b0);

        // Partial final word.
        send_req(16'h0000, 16'd7);
        do_aw(16'h0000, 8'd1);
        do_w(2, 4'h7, 1'b1);
        do_b(3'd0);
        do_resp(1'b0);

        // 25 beats split by MAX_BURST.
        send_req(16'h0000, 16'd100);
        do_aw(16'h0000, 8'd15);
        do_w(16, 4'hF, 1'b0);
        do_aw(16'h0040, 8'd8);
        do_w(9, 4'hF, 1'b1);
        do_b(3'd0);
        do_b(3'd0);
        do_resp(1'b0);

        // Split at the 4 KiB page.
        send_req(16'h0FF0, 16'd64);
        do_aw(16'h0FF0, 8'd3);
        do_w(4, 4'hF, 1'b0);
        do_aw(16'h1000, 8'd11);
        do_w(12, 4'hF, 1'b1);
        do_b(3'd0);
        do_b(3'd0);
        do_resp(1'b0);

        // Error on first burst only; response waits for both B.
        send_req(16'h0200, 16'd100);
        do_aw(16'h0200, 8'd15);
        do_w(16, 4'hF, 1'b0);
        do_aw(16'h0240, 8'd8);
        do_w(9, 4'hF, 1'b1);
        do_b(3'd2);
        #1;
        check("resp_after_one_b", 32'(resp_vld), 32'd0);
        do_b(3'd0);
        do_resp(1'b1);
        send_req(16'h0300, 16'd8);
        do_aw(16'h0300, 8'd1);
        do_w(2, 4'hF, 1'b1);
        do_b(3'd0);
        do_resp(1'b0);

        // Outstanding limit: third AW waits for a B, then AW and B land together.
        send_req(16'h0000, 16'd192);
        do_aw(16'h0000, 8'd15);
        do_w(16, 4'hF, 1'b0);
        do_aw(16'h0040, 8'd15);
        do_w(16, 4'hF, 1'b0);
        #1;
        check("aw_stall", 32'(axi_aw_awvalid), 32'd0);
        do_b(3'd0);
        wait_aw();
        check("aw3_addr", 32'(axi_aw_awaddr), 32'h0080);
        check("aw3_len", 32'(axi_aw_awlen), 32'd15);
        axi_aw_awready = 1'b1; axi_b_bvalid = 1'b1; axi_b_bresp = 3'd0;
        $display("AW addr=%h awlen=%0d with B", axi_aw_awaddr, axi_aw_awlen);
        @(negedge clk);
        axi_aw_awready = 1'b0; axi_b_bvalid = 1'b0;
        do_w(16, 4'hF, 1'b1);
        do_b(3'd0);
        do_resp(1'b0);

        // Misaligned address and zero length: no AXI traffic.
        send_req(16'h0102, 16'd8);
        #1;
        check("misalign_awvalid", 32'(axi_aw_awvalid), 32'd0);
        do_resp(1'b1);
        send_req(16'h0100, 16'd0);
        #1;
        check("zero_awvalid", 32'(axi_aw_awvalid), 32'd0);
        do_resp(1'b0);

        // Reset in the middle of a data beat.
        send_req(16'h0100, 16'd8);
        do_aw(16'h0100, 8'd1);
        data_in_vld = 1'b1; axi_w_wready = 1'b1;
        #1;
        check("pre_rst_wvalid", 32'(axi_w_wvalid), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_wvalid", 32'(axi_w_wvalid), 32'd0);
        check("midrst_data_rdy", 32'(data_in_rdy), 32'd0);
        check("midrst_awvalid", 32'(axi_aw_awvalid), 32'd0);
        check("midrst_resp_vld", 32'(resp_vld), 32'd0);
        check("midrst_req_rdy", 32'(req_rdy), 32'd0);
        check("midrst_awaddr", 32'(axi_aw_awaddr), 32'd0);
        check("midrst_wstrb", 32'(axi_w_wstrb), 32'd0);
        check("midrst_wlast", 32'(axi_w_wlast), 32'd0);
        @(negedge clk);
        rst = 1'b0; data_in_vld = 1'b0; axi_w_wready = 1'b0;
        #1;
        check("post_rst_req_rdy", 32'(req_rdy), 32'd1);
        check("post_rst_bready", 32'(axi_b_bready), 32'd0);
        @(negedge clk);
        send_req(16'h0300, 16'd4);
        do_aw(16'h0300, 8'd0);
        do_w(1, 4'hF, 1'b1);
        do_b(3'd0);
        do_resp(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
